calc_ctrl: RTL and testbench
============================

CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 Parameter ADDR_W, default 13, SRAM word-address width.
REQ-002 Parameter DATA_W, default 32, SRAM word width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle start pulse, driven from STAT_REG_WR[0].
REQ-006 cfg_len  input  ADDR_W  element count N, from CONFIG_REG[12:0].
REQ-007 calc_base  input  ADDR_W  vector A base word address, from CALCBASE_REG[12:0].
REQ-008 rw_base  input  ADDR_W  result word address, from RWBASE_REG[12:0].
REQ-009 stat  output  16  status to STAT_REG_RD: [0] busy, [1] done, [2] err, [15:3] zero.
REQ-010 sram_rd_en  output  1  read strobe; read data is valid one cycle after it.
REQ-011 sram_rd_addr  output  ADDR_W  read word address.
REQ-012 sram_rd_data  input  DATA_W  read data.
REQ-013 sram_wr_en  output  1  write strobe.
REQ-014 sram_wr_addr  output  ADDR_W  write word address.
REQ-015 sram_wr_data  output  DATA_W  write data.

Function
REQ-016 The block SHALL compute the dot product of A[i] at calc_base+i and B[i] at calc_base+N+i for i = 0..N-1, and write the result to rw_base.
REQ-017 The product SHALL be the low 32 bits of A[i]*B[i]; the accumulator SHALL be 32 bits and wrap modulo 2^32.
REQ-018 All address sums SHALL wrap modulo 2^ADDR_W.
REQ-019 States SHALL be IDLE, RD_A, RD_B, MAC, WRITE.
REQ-020 IDLE: on start with N!=0, latch N, calc_base and rw_base; clear the accumulator, index, done and err; set busy; go to RD_A.
REQ-021 IDLE: on start with N==0, set done and err on the next edge; make no SRAM access; stay in IDLE.
REQ-022 RD_A: assert sram_rd_en with address calc_base+i; go to RD_B.
REQ-023 RD_B: capture sram_rd_data as A; assert sram_rd_en with address calc_base+N+i; go to MAC.
REQ-024 MAC: capture B; accumulate A*B; increment i; if i+1==N go to WRITE, else go to RD_A.
REQ-025 WRITE: pulse sram_wr_en for one cycle with the final accumulator on sram_wr_data; clear busy; set done; go to IDLE.
REQ-026 Start-to-done latency SHALL be 3N+1 cycles from the start edge to the edge that sets done.
REQ-027 start while busy SHALL be ignored; latched operands SHALL NOT change.
REQ-028 done and err SHALL be sticky until the next accepted start or reset.
REQ-029 sram_rd_en and sram_wr_en SHALL never be asserted in the same cycle; address and data outputs SHALL be zero when their strobe is low.
REQ-030 Input changes to cfg_len, calc_base or rw_base while busy SHALL have no effect.

Reset
REQ-031 On rst, the state SHALL return to IDLE and stat, both strobes, all addresses, sram_wr_data, the accumulator and the index SHALL become 0 immediately.
REQ-032 If rst is asserted mid-operation, the operation SHALL be abandoned, with no write and done=0 after release.

Structure
REQ-033 A shared package calc_pkg SHALL hold the state enum, the ADDR_W/DATA_W defaults and the stat bit-index constants (BUSY_BIT=0, DONE_BIT=1, ERR_BIT=2).
REQ-034 The block SHALL contain one sub-module, calc_mac, holding the registered 32-bit multiply-accumulate with clear and enable inputs.

Verification
REQ-035 SRAM model preloaded A={1,2,3} at 0x010, B={4,5,6} at 0x013; N=3, rw_base=0x100; start -> write 32 to 0x100; done at cycle 10; stat=0x0002.
REQ-036 N=0; start -> no SRAM strobes; stat=0x0006 one cycle later.
REQ-037 calc_base=0x1FFF, N=2 -> reads at 0x1FFF, 0x0000, 0x0001, 0x0002 (wrap); result correct.
REQ-038 A={0x80000000}, B={2}, N=1 -> product wraps; write 0x00000000.
REQ-039 Second start pulse at cycle 4 of a running N=3 job -> ignored; single write; result unchanged.
REQ-040 rst asserted at cycle 5 of an N=3 job -> all outputs 0 immediately; no write; a following start runs cleanly.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calc_ctrl dot-product engine.
//   state_t      : controller FSM states
//   ADDR_W_DEF   : default SRAM word-address width
//   DATA_W_DEF   : default SRAM word width
//   STAT_W       : width of the status word
//   *_BIT        : bit positions inside the status word
package calc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    MAC   = 3'd3,
    WRITE = 3'd4
  } state_t;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 32;
  localparam int STAT_W     = 16;

  localparam int BUSY_BIT = 0;
  localparam int DONE_BIT = 1;
  localparam int ERR_BIT  = 2;

endpackage

// File: rtl/calc_ctrl_if.sv
// calc_ctrl_if: single-port-per-direction SRAM bus between calc_ctrl and the
// vector memory.
//   rd_en / rd_addr : read strobe and word address (data returns next cycle)
//   rd_data         : read data from memory
//   wr_en / wr_addr / wr_data : write strobe, word address and data
// Modports: master = controller side, slave = memory side.
interface calc_ctrl_if
  import calc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data
  );

endinterface

// File: rtl/calc_mac.sv
// calc_mac: registered multiply-accumulate.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous clear of the accumulator (has priority over en)
//   en       : add a*b into the accumulator this cycle
//   a, b     : operands
//   acc      : accumulator; product and sum keep only the low W bits
module calc_mac #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] acc
);

  logic [W-1:0] acc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      // Evaluated in a W-bit context, so both the product and the sum wrap.
      acc_reg <= acc_reg + a * b;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: dot-product engine over SRAM-resident vectors.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : one-cycle start pulse (ignored while busy)
//   cfg_len   : element count N
//   calc_base : word address of A[0]; B[0] follows at calc_base+N
//   rw_base   : word address that receives the result
//   stat      : [0] busy, [1] done, [2] err, upper bits zero
//   sram      : SRAM bus (master side)
// Each element costs three cycles (RD_A, RD_B, MAC) and the final WRITE adds
// one, so done rises 3N+1 edges after the start edge.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [ADDR_W-1:0] calc_base,
  input  logic [ADDR_W-1:0] rw_base,
  output logic [STAT_W-1:0] stat,
  calc_ctrl_if.master       sram
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] n_reg, base_reg, rw_reg, idx_reg;
  logic [DATA_W-1:0] a_reg;
  logic              done_reg, err_reg;
  logic [DATA_W-1:0] acc;

  logic accept_start, zero_start, last_elem;

  // A start is only looked at in IDLE; that alone makes it ignored while busy.
  assign accept_start = (state_reg == IDLE) && start && (cfg_len != '0);
  assign zero_start   = (state_reg == IDLE) && start && (cfg_len == '0);
  assign last_elem    = (idx_reg + ADDR_W'(1)) == n_reg;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept_start) state_next = RD_A;
      RD_A:    state_next = RD_B;
      RD_B:    state_next = MAC;
      MAC:     state_next = last_elem ? WRITE : RD_A;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  // Strobes, addresses and write data are decoded from the state register so
  // that an asynchronous reset forces them to zero in the same instant.
  logic              rd_en_c, wr_en_c;
  logic [ADDR_W-1:0] rd_addr_c, wr_addr_c;
  logic [DATA_W-1:0] wr_data_c;

  always_comb begin
    rd_en_c   = 1'b0;
    rd_addr_c = '0;
    wr_en_c   = 1'b0;
    wr_addr_c = '0;
    wr_data_c = '0;
    case (state_reg)
      RD_A: begin
        rd_en_c   = 1'b1;
        rd_addr_c = base_reg + idx_reg;
      end
      RD_B: begin
        rd_en_c   = 1'b1;
        rd_addr_c = base_reg + n_reg + idx_reg;
      end
      WRITE: begin
        wr_en_c   = 1'b1;
        wr_addr_c = rw_reg;
        wr_data_c = acc;
      end
      default: ;
    endcase
  end

  assign sram.rd_en   = rd_en_c;
  assign sram.rd_addr = rd_addr_c;
  assign sram.wr_en   = wr_en_c;
  assign sram.wr_addr = wr_addr_c;
  assign sram.wr_data = wr_data_c;

  // busy is exactly "not in IDLE": it rises on the start edge and falls on
  // the WRITE edge, the same edges that move the FSM in and out of IDLE.
  always_comb begin
    stat           = '0;
    stat[BUSY_BIT] = (state_reg != IDLE);
    stat[DONE_BIT] = done_reg;
    stat[ERR_BIT]  = err_reg;
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg    <= '0;
      base_reg <= '0;
      rw_reg   <= '0;
      idx_reg  <= '0;
      a_reg    <= '0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept_start) begin
            n_reg    <= cfg_len;
            base_reg <= calc_base;
            rw_reg   <= rw_base;
            idx_reg  <= '0;
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
          end else if (zero_start) begin
            // Empty job: report completion with error, touch no memory.
            done_reg <= 1'b1;
            err_reg  <= 1'b1;
          end
        end
        RD_B:    a_reg    <= sram.rd_data;  // data for the RD_A read
        MAC:     idx_reg  <= idx_reg + ADDR_W'(1);
        WRITE:   done_reg <= 1'b1;
        default: ;
      endcase
    end
  end

  // B arrives on rd_data during MAC and goes straight into the multiplier.
  calc_mac #(
    .W (DATA_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (accept_start),
    .en  (state_reg == MAC),
    .a   (a_reg),
    .b   (sram.rd_data),
    .acc (acc)
  );

endmodule

// File: tb/tb_calc_ctrl.sv
module tb_calc_ctrl;
  import calc_pkg::*;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_len, calc_base, rw_base;
  logic [15:0]   stat;

  calc_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) sif ();

  calc_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .calc_base (calc_base),
    .rw_base   (rw_base),
    .stat      (stat),
    .sram      (sif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------- SRAM model
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          rd_pend_en = 1'b0;
  logic [AW-1:0] rd_pend_addr = '0;

  // Requests are sampled mid-cycle and answered on the next rising edge.
  always @(negedge clk) begin
    rd_pend_en   = sif.rd_en;
    rd_pend_addr = sif.rd_addr;
  end

  always @(posedge clk) begin
    if (rd_pend_en) sif.rd_data <= mem[rd_pend_addr];
  end

  // ----------------------------------------------------- scoreboard/monitor
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic [AW-1:0] rd_log[$];
  int            n_writes = 0;
  int            viol = 0;

  always @(negedge clk) begin
    if (sif.rd_en && sif.wr_en) viol++;
    if (!sif.rd_en && sif.rd_addr != '0) viol++;
    if (!sif.wr_en && (sif.wr_addr != '0 || sif.wr_data != '0)) viol++;
    if (sif.rd_en) rd_log.push_back(sif.rd_addr);
    if (sif.wr_en) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", {19'd0, sif.wr_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", {19'd0, sif.wr_addr}, {19'd0, e.addr});
        chk("write_data", sif.wr_data, e.data);
      end
    end
  end

  // ----------------------------------------------------------------- vectors
  typedef struct {
    string           name;
    logic [AW-1:0]   base;
    logic [AW-1:0]   n;
    logic [AW-1:0]   rw;
    logic [3:0][DW-1:0] a;
    logic [3:0][DW-1:0] b;
    logic [DW-1:0]   exp_res;
    logic [15:0]     exp_stat;
    int              exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic preload(input vec_t v);
    logic [AW-1:0] ad;
    for (int i = 0; i < int'(v.n); i++) begin
      ad = v.base + AW'(i);
      mem[ad] = v.a[i];
      ad = v.base + v.n + AW'(i);
      mem[ad] = v.b[i];
    end
  endtask

  task automatic pulse_start(input vec_t v);
    @(negedge clk);
    cfg_len   = v.n;
    calc_base = v.base;
    rw_base   = v.rw;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_reads(input vec_t v);
    logic [AW-1:0] ea;
    chk({v.name, "_rd_count"}, rd_log.size(), 2 * int'(v.n));
    for (int i = 0; i < int'(v.n) && 2 * i + 1 < rd_log.size(); i++) begin
      ea = v.base + AW'(i);
      chk({v.name, "_rd_a_addr"}, {19'd0, rd_log[2*i]}, {19'd0, ea});
      ea = v.base + v.n + AW'(i);
      chk({v.name, "_rd_b_addr"}, {19'd0, rd_log[2*i+1]}, {19'd0, ea});
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    preload(v);
    rd_log.delete();
    if (v.n != '0) exp_q.push_back('{v.rw, v.exp_res});
    pulse_start(v);
    if (v.n != '0) chk({v.name, "_busy"}, {16'd0, stat}, 32'h0001);
    cyc = 0;
    while (!stat[DONE_BIT] && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk({v.name, "_latency"}, cyc, v.exp_lat);
    chk({v.name, "_stat"}, {16'd0, stat}, {16'd0, v.exp_stat});
    repeat (3) @(posedge clk);
    #1;
    chk({v.name, "_pending"}, exp_q.size(), 0);
    check_reads(v);
    $display("job %s: N=%0d base=0x%0h rw=0x%0h latency=%0d stat=0x%04h",
             v.name, v.n, v.base, v.rw, cyc, stat);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    int cyc;
    int w0;

    vecs[0] = '{"basic", 13'h010, 13'd3, 13'h100,
                {32'd0, 32'd3, 32'd2, 32'd1}, {32'd0, 32'd6, 32'd5, 32'd4},
                32'd32, 16'h0002, 10};
    vecs[1] = '{"addr_wrap", 13'h1FFF, 13'd2, 13'h0200,
                {32'd0, 32'd0, 32'd9, 32'd7}, {32'd0, 32'd0, 32'h10, 32'd3},
                32'd165, 16'h0002, 7};
    vecs[2] = '{"prod_wrap", 13'h020, 13'd1, 13'h0300,
                {32'd0, 32'd0, 32'd0, 32'h8000_0000}, {32'd0, 32'd0, 32'd0, 32'd2},
                32'h0000_0000, 16'h0002, 4};
    vecs[3] = '{"acc_wrap", 13'h040, 13'd4, 13'h1FFF,
                {32'd3, 32'd2, 32'd1, 32'hFFFF_FFFF}, {32'd5, 32'd4, 32'd3, 32'd2},
                32'h0000_0018, 16'h0002, 13};
    vecs[4] = '{"zero_len", 13'h050, 13'd0, 13'h0400,
                {32'd0, 32'd0, 32'd0, 32'd0}, {32'd0, 32'd0, 32'd0, 32'd0},
                32'd0, 16'h0006, 0};

    rst = 1'b1;
    start = 1'b0;
    cfg_len = '0;
    calc_base = '0;
    rw_base = '0;
    #1;
    chk("reset_stat", {16'd0, stat}, 32'h0);
    chk("reset_rd_en", {31'd0, sif.rd_en}, 32'h0);
    chk("reset_wr_en", {31'd0, sif.wr_en}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    foreach (vecs[k]) run_vec(vecs[k]);

    // Second start mid-job with different operands must be ignored.
    preload(vecs[0]);
    rd_log.delete();
    w0 = n_writes;
    exp_q.push_back('{vecs[0].rw, vecs[0].exp_res});
    pulse_start(vecs[0]);
    cyc = 0;
    while (!stat[DONE_BIT] && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
      if (cyc == 3) begin
        start = 1'b1;
        cfg_len = 13'd5;
        calc_base = 13'h700;
        rw_base = 13'h222;
      end else if (cyc == 4) begin
        start = 1'b0;
      end
    end
    chk("restart_latency", cyc, 10);
    chk("restart_stat", {16'd0, stat}, 32'h0002);
    repeat (5) @(posedge clk);
    #1;
    chk("restart_writes", n_writes - w0, 1);
    chk("restart_pending", exp_q.size(), 0);
    check_reads(vecs[0]);
    $display("job restart_ignored: latency=%0d writes=%0d stat=0x%04h",
             cyc, n_writes - w0, stat);

    // Reset in the middle of a job: everything drops at once, nothing written.
    preload(vecs[0]);
    w0 = n_writes;
    pulse_start(vecs[0]);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_stat", {16'd0, stat}, 32'h0);
    chk("midrst_rd_en", {31'd0, sif.rd_en}, 32'h0);
    chk("midrst_wr_en", {31'd0, sif.wr_en}, 32'h0);
    chk("midrst_rd_addr", {19'd0, sif.rd_addr}, 32'h0);
    chk("midrst_wr_addr", {19'd0, sif.wr_addr}, 32'h0);
    chk("midrst_wr_data", sif.wr_data, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("midrst_done_low", {16'd0, stat}, 32'h0);
    chk("midrst_no_write", n_writes - w0, 0);
    $display("job mid_reset: writes=%0d stat=0x%04h", n_writes - w0, stat);
    run_vec(vecs[0]);

    chk("strobe_rules", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
